mult_share_arbiter: RTL and testbench
=====================================

// Module: mult_share_arbiter
// PURPOSE
//  Shares one shift-add multiplier datapath (controller + BITS-wide datapath) among NREQ requesters.
//  Round-robin arbitration; latches the winner's operands, pulses start, waits for done with a
//  watchdog, returns the product and a one-cycle done pulse to the served requester.
//  Sits between the client blocks and the multiplier instance. Only one operation is in flight.
// PARAMETERS
//  NREQ     4   number of requesters, 2..8
//  BITS     8   operand width (multiplicand B, multiplier Q)
//  TIMEOUT  32  max cycles in WAIT before the operation is aborted with err; >= BITS+4
//  (localparam PW = 2*BITS+1, the product width of the datapath; 17 for BITS=8)
// PORTS
//  clk          in   1          rising-edge clock
//  rst          in   1          asynchronous reset, active high
//  req          in   NREQ       request per client; held high until its done pulse
//  op_b         in   NREQ*BITS  multiplicand per client; client i uses [i*BITS +: BITS]
//  op_q         in   NREQ*BITS  multiplier per client; same packing as op_b
//  gnt          out  NREQ       one-hot grant, high from START through DONE
//  done         out  NREQ       one-hot, one-cycle completion pulse to the granted client
//  result       out  PW         product; valid in the cycle done is high, held until next DONE
//  err          out  1          high with done when the watchdog fired; result is 0 in that case
//  busy         out  1          high in every state except IDLE
//  mul_start    out  1          one-cycle start pulse to the multiplier
//  mul_b        out  BITS       registered multiplicand to the multiplier
//  mul_q        out  BITS       registered multiplier to the multiplier
//  mul_done     in   1          multiplier ready/done (level or pulse)
//  mul_product  in   PW         multiplier product, sampled when mul_done is high in WAIT
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, timer=0; gnt, done, result, err, busy, mul_start, mul_b, mul_q all 0.
//  Reset mid-operation aborts immediately with no done pulse; the client must re-request.
//  All outputs are registered. FSM: IDLE -> START -> WAIT -> DONE -> IDLE.
//  IDLE:  req is sampled only here. If req!=0, winner = first set bit scanning rr_ptr, rr_ptr+1, ...
//         (mod NREQ). Register sel, mul_b/mul_q <= winner operands, go START. Otherwise stay.
//  START: mul_start=1 (exactly one cycle), gnt[sel]=1, timer<=0, go WAIT. mul_done is ignored here.
//  WAIT:  timer increments each cycle. If mul_done=1: result<=mul_product, err<=0, go DONE.
//         Else if timer==TIMEOUT-1: result<=0, err<=1, go DONE. mul_done wins when both occur
//         in the same cycle.
//  DONE:  done[sel]=1 for one cycle, gnt[sel] still 1; rr_ptr<=(sel+1) mod NREQ; go IDLE.
//         gnt drops on the next cycle.
//  Min latency from req (IDLE) to done = 3 + multiplier cycles. Back-to-back service: a new
//  grant's START is 2 cycles after the previous DONE.
//  Requester drops req during the operation: the operation still completes and done still pulses.
//  Operand changes after IDLE have no effect; mul_b and mul_q are stable from START to DONE.
//  Arithmetic: unsigned; result is PW bits wide with zero-extension. No truncation is allowed.
//  Timer width = clog2(TIMEOUT+1); the timer saturates and never wraps.
// TESTING
//  1 Single client: req[0]=1, b=12, q=10, stub multiplier done after 9 cycles -> mul_start once,
//    gnt=0001, done=0001 one cycle, result=120, err=0.
//  2 Max operands: b=255, q=255 on client 2 -> result=65025 (PW=17), err=0.
//  3 Simultaneous req=1111 held after reset -> grant order 0,1,2,3,0; each done is one-hot.
//  4 Fairness: req=0101 always high -> grants alternate 0,2,0,2; client 0 never served twice
//    in a row.
//  5 Watchdog: stub never raises mul_done -> done pulse exactly TIMEOUT cycles after START+1,
//    err=1, result=0; the next request is still served.
//  6 rst pulsed mid-WAIT -> all outputs 0 asynchronously, no done pulse; after release,
//    req=0010 is served normally.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// Round-robin front end that shares one shift-add multiplier among NREQ clients.
// One operation in flight; watchdog aborts a stalled multiplier with err.
module mult_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int BITS    = 8,
  parameter int TIMEOUT = 32,
  localparam int PW     = 2*BITS+1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*BITS-1:0] op_b,
  input  logic [NREQ*BITS-1:0] op_q,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [PW-1:0]     result,
  output logic              err,
  output logic              busy,
  output logic              mul_start,
  output logic [BITS-1:0]   mul_b,
  output logic [BITS-1:0]   mul_q,
  input  logic              mul_done,
  input  logic [PW-1:0]     mul_product
);

  localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT+1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     sel_q, sel_d;
  logic [SW-1:0]     rr_q, rr_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [PW-1:0]     result_q, result_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              start_q, start_d;
  logic [BITS-1:0]   b_q, b_d;
  logic [BITS-1:0]   q_q, q_d;

  logic [SW-1:0]     win;
  logic [SW:0]       scan_sum;

  // Highest offset first so the client nearest rr_q overwrites the rest.
  always_comb begin
    win      = rr_q;
    scan_sum = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      scan_sum = {1'b0, rr_q} + (SW+1)'(k);
      if (scan_sum >= (SW+1)'(NREQ))
        scan_sum = scan_sum - (SW+1)'(NREQ);
      if (req[scan_sum[SW-1:0]])
        win = scan_sum[SW-1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_d     = rr_q;
    timer_d  = timer_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    result_d = result_q;
    err_d    = err_q;
    busy_d   = busy_q;
    start_d  = 1'b0;
    b_d      = b_q;
    q_d      = q_q;
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d = S_START;
          sel_d   = win;
          b_d     = op_b[int'(win)*BITS +: BITS];
          q_d     = op_q[int'(win)*BITS +: BITS];
          start_d = 1'b1;
          gnt_d   = NREQ'(1) << win;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        state_d = S_WAIT;
        timer_d = '0;
      end
      S_WAIT: begin
        if (timer_q != TW'(TIMEOUT))
          timer_d = timer_q + TW'(1);
        if (mul_done) begin
          result_d = mul_product;
          err_d    = 1'b0;
          done_d   = gnt_q;
          state_d  = S_DONE;
        end else if (timer_q == TW'(TIMEOUT-1)) begin
          result_d = '0;
          err_d    = 1'b1;
          done_d   = gnt_q;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        if (sel_q == SW'(NREQ-1))
          rr_d = '0;
        else
          rr_d = sel_q + SW'(1);
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      rr_q     <= '0;
      timer_q  <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      b_q      <= '0;
      q_q      <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_q     <= rr_d;
      timer_q  <= timer_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      start_q  <= start_d;
      b_q      <= b_d;
      q_q      <= q_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign result    = result_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign mul_start = start_q;
  assign mul_b     = b_q;
  assign mul_q     = q_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: vector table, reset/watchdog sequences and
// randomized traffic against a round-robin reference model with a stub multiplier.
module tb_mult_share_arbiter;

  localparam int NREQ    = 4;
  localparam int BITS    = 8;
  localparam int TIMEOUT = 32;
  localparam int PW      = 2*BITS+1;

  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0] req;
  logic [NREQ*BITS-1:0] op_b, op_q;
  logic [NREQ-1:0] gnt, done;
  logic [PW-1:0] result;
  logic err, busy, mul_start;
  logic [BITS-1:0] mul_b, mul_q;
  logic mul_done;
  logic [PW-1:0] mul_product;

  logic [7:0] ob[NREQ];
  logic [7:0] oq[NREQ];

  assign op_b = {ob[3], ob[2], ob[1], ob[0]};
  assign op_q = {oq[3], oq[2], oq[1], oq[0]};

  mult_share_arbiter #(
    .NREQ(NREQ), .BITS(BITS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req(req),
    .op_b(op_b), .op_q(op_q),
    .gnt(gnt), .done(done), .result(result),
    .err(err), .busy(busy), .mul_start(mul_start),
    .mul_b(mul_b), .mul_q(mul_q),
    .mul_done(mul_done), .mul_product(mul_product)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Stub multiplier: pulses mul_done stub_dly cycles after start (0 = never)
  int stub_dly = 1;
  int cnt = 0;
  logic [PW-1:0] pr = '0;
  assign mul_product = pr;

  always @(posedge clk) begin
    if (rst) begin
      cnt <= 0;
      mul_done <= 1'b0;
    end else begin
      mul_done <= 1'b0;
      if (mul_start) begin
        cnt <= stub_dly;
        pr  <= PW'(mul_b) * PW'(mul_q);
      end else if (cnt != 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) mul_done <= 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: round-robin pointer as a plain integer
  int rr_m = 0;

  function automatic int pick(input logic [NREQ-1:0] m);
    for (int k = 0; k < NREQ; k++)
      if (m[(rr_m + k) % NREQ]) return (rr_m + k) % NREQ;
    return -1;
  endfunction

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_start"}, mul_start, 0);
    chk({tag, "_mulb"}, mul_b, 0);
    chk({tag, "_mulq"}, mul_q, 0);
  endtask

  task automatic run_op(input logic [NREQ-1:0] mask, input int dly,
                        input bit drop, input int w, input int res,
                        input bit e);
    int n, s, lat, extra;
    logic [7:0] eb, eq;
    logic [NREQ-1:0] oh;
    oh = NREQ'(1) << w;
    eb = ob[w];
    eq = oq[w];
    lat = (dly > 0 && dly <= TIMEOUT-1) ? dly + 2 : TIMEOUT + 1;
    stub_dly = dly;
    req = mask;
    n = 0;
    do begin @(negedge clk); n++; end while (!mul_start && n < 8);
    chk("start_seen", mul_start, 1);
    chk("gnt_at_start", gnt, oh);
    chk("mul_b", mul_b, eb);
    chk("mul_q", mul_q, eq);
    chk("busy_at_start", busy, 1);
    s = cyc;
    extra = 0;
    if (drop) req = '0;
    for (int i = 0; i < NREQ; i++) begin
      ob[i] = 8'($urandom);
      oq[i] = 8'($urandom);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (mul_start) extra++;
    end while (done == '0 && n < TIMEOUT + 8);
    chk("done_onehot", done, oh);
    chk("gnt_at_done", gnt, oh);
    chk("result", result, res);
    chk("err", err, e);
    chk("latency", cyc - s, lat);
    chk("single_start", extra, 0);
    chk("mul_b_stable", mul_b, eb);
    req = '0;
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("gnt_drop", gnt, 0);
    chk("result_hold", result, res);
    chk("busy_idle", busy, 0);
    rr_m = (w + 1) % NREQ;
  endtask

  typedef struct {
    logic [NREQ-1:0] req;
    logic [7:0] b;
    logic [7:0] q;
    int dly;
    int w;
    int res;
    bit err;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl[NV];

  initial begin
    int seen, mask, w, r, dly, res;
    bit e, drop;

    tbl[0]  = '{4'b1111, 8'd3,   8'd5,   1,  0, 15,    1'b0};
    tbl[1]  = '{4'b1111, 8'd7,   8'd9,   4,  1, 63,    1'b0};
    tbl[2]  = '{4'b1111, 8'd0,   8'd200, 2,  2, 0,     1'b0};
    tbl[3]  = '{4'b1111, 8'd16,  8'd16,  3,  3, 256,   1'b0};
    tbl[4]  = '{4'b1111, 8'd1,   8'd255, 1,  0, 255,   1'b0};
    tbl[5]  = '{4'b0001, 8'd12,  8'd10,  9,  0, 120,   1'b0};
    tbl[6]  = '{4'b0100, 8'd255, 8'd255, 8,  2, 65025, 1'b0};
    tbl[7]  = '{4'b0101, 8'd2,   8'd3,   2,  0, 6,     1'b0};
    tbl[8]  = '{4'b0101, 8'd4,   8'd5,   2,  2, 20,    1'b0};
    tbl[9]  = '{4'b0101, 8'd6,   8'd7,   2,  0, 42,    1'b0};
    tbl[10] = '{4'b0101, 8'd8,   8'd9,   2,  2, 72,    1'b0};
    tbl[11] = '{4'b1000, 8'd200, 8'd100, 31, 3, 20000, 1'b0};
    tbl[12] = '{4'b0010, 8'd10,  8'd10,  32, 1, 0,     1'b1};
    tbl[13] = '{4'b0010, 8'd11,  8'd11,  0,  1, 0,     1'b1};
    tbl[14] = '{4'b0100, 8'd9,   8'd9,   5,  2, 81,    1'b0};

    rst = 1'b1;
    req = '0;
    for (int i = 0; i < NREQ; i++) begin
      ob[i] = '0;
      oq[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_req", busy, 0);

    for (int i = 0; i < NV; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        ob[j] = 8'($urandom);
        oq[j] = 8'($urandom);
      end
      ob[tbl[i].w] = tbl[i].b;
      oq[tbl[i].w] = tbl[i].q;
      run_op(tbl[i].req, tbl[i].dly, 1'b0, tbl[i].w, tbl[i].res, tbl[i].err);
    end

    // Reset in the middle of WAIT
    ob[3] = 8'hC3;
    oq[3] = 8'h5A;
    stub_dly = 20;
    req = 4'b1000;
    seen = 0;
    do begin @(negedge clk); seen++; end while (!mul_start && seen < 8);
    chk("rst_seq_start", mul_start, 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_outs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done != '0) seen++;
    end
    chk("no_done_after_rst", seen, 0);
    rr_m = 0;
    ob[1] = 8'd21;
    oq[1] = 8'd3;
    run_op(4'b0010, 6, 1'b0, 1, 63, 1'b0);

    // Randomized traffic against the model
    for (int it = 0; it < 60; it++) begin
      mask = $urandom_range(1, 15);
      for (int j = 0; j < NREQ; j++) begin
        ob[j] = 8'($urandom);
        oq[j] = 8'($urandom);
      end
      r = $urandom_range(0, 9);
      dly = (r == 0) ? 0 : (r == 1) ? TIMEOUT : $urandom_range(1, 12);
      drop = ($urandom_range(0, 3) == 0);
      w = pick(4'(mask));
      e = !(dly > 0 && dly < TIMEOUT);
      res = e ? 0 : int'(ob[w]) * int'(oq[w]);
      run_op(4'(mask), dly, drop, w, res, e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
